seq_multi: RTL and testbench
============================

Name: seq_multi

Overview:
- Sequential shift-and-add unsigned multiplier.
- Accepts two WIDTH-bit operands on a start pulse and computes the 2*WIDTH-bit product over WIDTH clock cycles, one partial product per cycle.
- Signals completion with a one-cycle done pulse.
- Small arithmetic leaf block for area-constrained datapaths where a combinational multiplier is not wanted.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising clk, accepted only in IDLE.
- a  input  WIDTH  multiplicand, unsigned; sampled when start is accepted.
- b  input  WIDTH  multiplier, unsigned; sampled when start is accepted.
- p  output  2*WIDTH  product register; holds last completed result.
- done  output  1  registered one-cycle completion pulse.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; p=0; done=0.
  - Internal accumulator, operand registers and counter cleared.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded and no done is produced.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - On a rising edge with start=1, latch mcand={WIDTH'b0,a} (2*WIDTH bits), mplier=b, acc=0, cnt=0, then go to BUSY.
  - start=0: remain in IDLE.
- BUSY, each rising edge:
  - If mplier[0]=1, acc <= acc + mcand; otherwise acc unchanged.
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th iteration): p <= final sum (acc plus the last conditional add); done <= 1; state <= IDLE.
- Latency: if start is accepted at edge E0, the iterations occur at edges E1..E_WIDTH. p and done update at E_WIDTH. done is high for exactly one clock period after E_WIDTH.
- done is 0 in every other cycle.
- p changes only at completion or reset. During BUSY it keeps the previous result; it is never cleared by start.
- start while BUSY is ignored, with no effect on the operation or operands.
- a and b may change freely after acceptance.
- Back-to-back operation: start high in the done cycle is accepted, since the FSM is already in IDLE.
- start held high continuously produces repeated operations, each WIDTH+1 cycles apart.
- Arithmetic is unsigned. acc is 2*WIDTH bits and cannot overflow: the maximum result is (2^WIDTH-1)^2 < 2^(2*WIDTH).
- Counter width is clog2(WIDTH)+1 bits.

Decomposition:
- Shared package holds:
  - state enum type (IDLE, BUSY);
  - localparam helpers for product width and counter width (clog2).
- Single module; no sub-module needed.
- An optional combinational "conditional add" helper may stay inline.

Test Plan:
- 10 ns clock; rst low for 10 ns then high; a=4'b1010, b=4'b0011, start high for one cycle (sampled at edge E0) -> done high exactly one cycle after edge E0+4; p=8'd30; p stays 30 afterwards.
- a=15, b=15 -> p=225 at done. a=0, b=9 -> p=0 with done pulse. a=7, b=0 -> p=0 with done pulse. a=1, b=13 -> p=13.
- Back-to-back: 6*5 followed by start in the done cycle with 9*11 -> p=30 then p=99; the second done comes 5 cycles after the first.
- start pulses and operand changes at cycles 2 and 3 of BUSY during 12*12 -> ignored; p=144; only one done pulse.
- Assert rst low mid-BUSY of 14*3 -> p=0 and done=0 immediately (asynchronously); no done afterwards. A new 2*3 request then yields p=6.
- Exhaustive self-check over all 256 operand pairs with start issued in each done cycle -> p equals a*b at every done; p unchanged while BUSY; done never wider than one cycle.

Source files
------------

// File: rtl/seq_multi_pkg.sv
// Shared types and width helpers for the sequential shift-and-add multiplier.
package seq_multi_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Product width for a given operand width.
  function automatic int unsigned prod_width(input int unsigned w);
    return 2 * w;
  endfunction

  // Iteration counter width: clog2(w)+1 bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_multi.sv
// Sequential unsigned multiplier: one conditional add per clock, WIDTH
// iterations, product registered with a one-cycle done pulse.
module seq_multi
  import seq_multi_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [2*WIDTH-1:0]    p,
  output logic                  done
);

  localparam int unsigned PW = prod_width(WIDTH);
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic            done_q, done_d;
  logic [PW-1:0]   sum;

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          p_d     = sum;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      done_q   <= done_d;
    end
  end

  assign p    = p_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_multi.sv
// Scoreboard bench for seq_multi: stimulus pushes expected product and
// completion cycle; a negedge monitor pops and checks on every done.
module tb_seq_multi;

  localparam int unsigned W = 4;

  typedef struct {
    logic [2*W-1:0] p;
    int unsigned    cyc;
    string          name;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2*W-1:0]   p;
  logic             done;

  exp_t             sb[$];
  int unsigned      cyc;
  int unsigned      tests;
  int unsigned      fails;
  logic [2*W-1:0]   prev_p;
  logic             prev_done;

  seq_multi #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to predict completion cycles.
  always @(posedge clk) cyc++;

  // Monitor: check product/latency on done, stability otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      prev_p    = p;
      prev_done = done;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 p=%0d, required no done", p);
        end else begin
          exp_t e;
          e = sb.pop_front();
          tests++;
          if (p !== e.p) begin
            fails++;
            $display("FAIL %s_p: got %0d, required %0d", e.name, p, e.p);
          end
          tests++;
          if (cyc != e.cyc) begin
            fails++;
            $display("FAIL %s_latency: done at cycle %0d, required %0d", e.name, cyc, e.cyc);
          end
        end
        tests++;
        if (prev_done) begin
          fails++;
          $display("FAIL done_width: got done high two cycles, required one");
        end
      end else begin
        tests++;
        if (p !== prev_p) begin
          fails++;
          $display("FAIL p_stable: got %0d, required %0d", p, prev_p);
        end
      end
      prev_p    = p;
      prev_done = done;
    end
  end

  // Drive a request at the current negedge; hold start for one cycle.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit expect_done, input string nm);
    exp_t e;
    start = 1'b1;
    a     = x;
    b     = y;
    if (expect_done) begin
      e.p    = (2*W)'(x) * (2*W)'(y);
      e.cyc  = cyc + 1 + W;
      e.name = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Return at the negedge where done is seen, or flag a timeout.
  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2*W + 4; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done, required done within %0d cycles", nm, 2*W + 4);
    end
  endtask

  task automatic check(input string nm, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  initial begin
    logic [W-1:0] ta [5];
    logic [W-1:0] tb_ [5];
    tests = 0; fails = 0; cyc = 0;
    prev_p = '0; prev_done = 1'b0;
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    #2;
    check("reset_p", p, 8'd0);
    check("reset_done", {7'd0, done}, 8'd0);
    #8 rst = 1'b1;           // t=10, a negedge
    @(negedge clk);

    // Basic 10*3 with latency check, then hold value.
    issue(4'b1010, 4'b0011, 1'b1, "mul10x3");
    wait_done("mul10x3");
    repeat (3) @(negedge clk);
    check("hold_30", p, 8'd30);

    // Directed operand patterns.
    ta  = '{4'd15, 4'd0, 4'd7, 4'd1, 4'd6};
    tb_ = '{4'd15, 4'd9, 4'd0, 4'd13, 4'd5};
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb_[i], 1'b1, "directed");
      wait_done("directed");
      @(negedge clk);
    end

    // Back-to-back: 6*5 then 9*11 issued in the done cycle.
    issue(4'd6, 4'd5, 1'b1, "b2b_first");
    wait_done("b2b_first");
    issue(4'd9, 4'd11, 1'b1, "b2b_second");
    wait_done("b2b_second");
    @(negedge clk);

    // start and operand changes while BUSY are ignored.
    issue(4'd12, 4'd12, 1'b1, "busy_ignore");
    start = 1'b1; a = 4'd3; b = 4'd5;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ignore");
    repeat (3) @(negedge clk);
    check("busy_ignore_hold", p, 8'd144);

    // Asynchronous reset mid-operation discards the result.
    issue(4'd14, 4'd3, 1'b0, "reset_mid");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_p", p, 8'd0);
    check("async_reset_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_p", p, 8'd0);
    issue(4'd2, 4'd3, 1'b1, "after_reset");
    wait_done("after_reset");
    @(negedge clk);

    // Exhaustive chain, each request issued in the previous done cycle.
    for (int i = 0; i < 256; i++) begin
      issue(W'(i >> 4), W'(i & 15), 1'b1, "exhaustive");
      wait_done("exhaustive");
    end
    repeat (3) @(negedge clk);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
